cache_nway: RTL and testbench
=============================

// Module: cache_nway
// PURPOSE
// - N-way set-associative, write-back/write-allocate cache: tag/data/valid/dirty arrays, tree-PLRU, control FSM in one block.
// - Sits between CPU-side 256-bit line port (I-/D-cache slot) and physical memory / arbiter port.
// - Generalises the fixed 4-way datapath: any power-of-2 way count, invalid-way-first victim choice, integrated FSM.
// PARAMETERS
// - s_offset  5                     log2 bytes per line (line = 8*2**s_offset bits)
// - s_index   4                     log2 sets
// - num_ways  4                     associativity; power of 2, >= 2 (elaboration $error otherwise)
// - s_tag     32-s_offset-s_index   tag width (derived, do not override)
// PORTS
// - clk                 in   1        clock, all state on rising edge
// - rst                 in   1        synchronous, active-high reset
// - mem_read            in   1        CPU read request, held until mem_resp
// - mem_write           in   1        CPU write request, held until mem_resp
// - mem_address         in   32       CPU address, stable while request held
// - mem_byte_enable256  in   2**s_offset  byte write mask
// - mem_wdata256        in   s_line   write line data
// - mem_rdata256        out  s_line   read line data, valid when mem_resp
// - mem_resp            out  1        one-cycle completion pulse
// - pmem_read/pmem_write out 1        memory requests, held until pmem_resp
// - pmem_address        out  32       line-aligned ({tag, idx, s_offset'b0})
// - pmem_wdata          out  s_line   victim line on writeback
// - pmem_rdata          in   s_line   fill line, valid with pmem_resp
// - pmem_resp           in   1        memory completion pulse
// - hit_count/miss_count/wb_count out 32  perf counters (see CONFIGURATION)
// BEHAVIOUR
// - Arrays are flip-flop based, combinational read by idx=mem_address[s_offset+:s_index].
// - Reset: FSM->COMPARE; all valid/dirty/PLRU bits 0; mem_resp, pmem_read, pmem_write, counters 0; data/tag contents undefined.
// - COMPARE: idle unless mem_read|mem_write. Hit = valid & tag match in any way (at most one).
//   Hit -> mem_resp=1 same cycle (0-cycle hit); write merges bytes per byte enable, sets dirty; PLRU updated on every hit.
//   Miss -> victim latched; dirty victim -> WRITEBACK, else -> ALLOCATE. mem_resp=0.
// - Both mem_read and mem_write high: treated as write.
// - Victim: lowest-index invalid way; if all valid, tree-PLRU way.
// - PLRU: num_ways-1 bits, heap order (node n children 2n+1, 2n+2); bit 0 = victim in left subtree.
//   Access sets each node on path to point away from accessed way; other nodes unchanged.
// - WRITEBACK: pmem_write=1, pmem_address={victim tag, idx, 0}, pmem_wdata=victim line; on pmem_resp -> ALLOCATE.
// - ALLOCATE: pmem_read=1, pmem_address={req tag, idx, 0}; on pmem_resp write pmem_rdata/tag to victim,
//   valid=1, dirty=0 -> COMPARE; request then hits and completes next cycle (PLRU touched then, not at fill).
// - Miss latency: clean = 1 + mem cycles + 1; dirty adds writeback round trip.
// - pmem_read and pmem_write never high together; pmem_resp in COMPARE ignored.
// - rst mid-WRITEBACK/ALLOCATE: pmem requests drop next cycle, no array write; outstanding memory op abandoned (arbiter resets too).
// CONFIGURATION
// - CACHE_PERF_CTR_EN defined: hit_count +1 per hit mem_resp, miss_count +1 per COMPARE->miss transition,
//   wb_count +1 per WRITEBACK pmem_resp; 32-bit, wrap at 2**32; cleared by rst.
// - Undefined: counter logic absent, counter outputs tied 32'h0.
// TESTING
// - Reset, read 0x0000_0100 -> pmem_read at 0x0000_0100, fill 0xA5..; mem_resp 1 cycle after pmem_resp, rdata=fill.
// - Write 0x0000_0104 be=0x0000_00F0 after fill -> mem_resp same cycle, bytes 4-7 updated, line dirty.
// - num_ways=4, fill tags 0..3 on set 0, touch ways 0,1,2 -> next miss evicts way 3; dirty victim writeback precedes allocate.
// - num_ways=8: 8 fills then access way 5 only -> victim never 5; PLRU bits match heap-path update.
// - rst asserted during ALLOCATE -> pmem_read 0 next cycle, all lines invalid, same address misses again.
// - CACHE_PERF_CTR_EN: 3 hits, 2 misses, 1 writeback -> counters 3/2/1; without macro all read 0.

Source files
------------

// File: rtl/cache_nway.sv
// N-way set-associative write-back/write-allocate cache with tree-PLRU replacement and integrated control FSM.
// Optional performance counters are enabled by defining CACHE_PERF_CTR_EN.
module cache_nway #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 4,
  parameter int unsigned num_ways = 4,
  parameter int unsigned s_tag    = 32 - s_offset - s_index,
  parameter int unsigned s_mask   = 2**s_offset,
  parameter int unsigned s_line   = 8*s_mask
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [s_mask-1:0] mem_byte_enable256,
  input  logic [s_line-1:0] mem_wdata256,
  output logic [s_line-1:0] mem_rdata256,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
);

  localparam int unsigned s_sets = 2**s_index;
  localparam int unsigned s_way  = $clog2(num_ways);

  if (num_ways < 2 || (num_ways & (num_ways - 1)) != 0) begin : g_bad_ways
    $error("cache_nway: num_ways must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t r_state, w_next;

  logic [s_line-1:0]   r_data  [num_ways][s_sets];
  logic [s_tag-1:0]    r_tag   [num_ways][s_sets];
  logic [num_ways-1:0] r_valid [s_sets];
  logic [num_ways-1:0] r_dirty [s_sets];
  logic [num_ways-2:0] r_plru  [s_sets];
  logic [s_way-1:0]    r_victim;

  logic [s_index-1:0]  w_idx;
  logic [s_tag-1:0]    w_tag;
  logic                w_req;
  logic [num_ways-1:0] w_hit_vec;
  logic                w_hit;
  logic [s_way-1:0]    w_hit_way;
  logic [s_way-1:0]    w_plru_way;
  logic [s_way-1:0]    w_victim;
  logic [num_ways-2:0] w_plru_new;
  logic [s_line-1:0]   w_merged;
  logic                w_hit_upd;
  logic                w_miss;
  logic                w_fill;
  logic [s_offset-1:0] w_unused_offset;

  assign w_idx           = mem_address[s_offset +: s_index];
  assign w_tag           = mem_address[31 -: s_tag];
  assign w_req           = (mem_read | mem_write) & ~rst;
  assign w_unused_offset = mem_address[s_offset-1:0];
  assign mem_rdata256    = r_data[w_hit_way][w_idx];

  always_comb begin
    w_hit_way = '0;
    for (int unsigned i = 0; i < num_ways; i++) begin
      w_hit_vec[i] = r_valid[w_idx][i] && (r_tag[i][w_idx] == w_tag);
      if (w_hit_vec[i]) w_hit_way = s_way'(i);
    end
    w_hit = |w_hit_vec;
  end

  // Walk the PLRU tree from the root; a 0 bit steers toward the left child.
  always_comb begin
    int unsigned n;
    logic        b;
    n = 0;
    for (int unsigned lvl = 0; lvl < s_way; lvl++) begin
      b = 1'b0;
      for (int unsigned k = 0; k < num_ways - 1; k++)
        if (k == n) b = r_plru[w_idx][k];
      n = 2*n + 1 + 32'(b);
    end
    w_plru_way = s_way'(n - (num_ways - 1));
  end

  // Walk up from the accessed leaf, pointing every ancestor at the other subtree.
  always_comb begin
    int unsigned n;
    int unsigned p;
    w_plru_new = r_plru[w_idx];
    n = 32'(w_hit_way) + num_ways - 1;
    for (int unsigned lvl = 0; lvl < s_way; lvl++) begin
      p = (n - 1) / 2;
      for (int unsigned k = 0; k < num_ways - 1; k++)
        if (k == p) w_plru_new[k] = (n == 2*p + 1);
      n = p;
    end
  end

  always_comb begin
    logic w_found;
    w_found  = 1'b0;
    w_victim = w_plru_way;
    for (int unsigned i = 0; i < num_ways; i++) begin
      if (!w_found && !r_valid[w_idx][i]) begin
        w_victim = s_way'(i);
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < s_mask; b++)
      w_merged[8*b +: 8] = mem_byte_enable256[b] ? mem_wdata256[8*b +: 8]
                                                 : r_data[w_hit_way][w_idx][8*b +: 8];
  end

  always_comb begin
    w_next       = r_state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {w_tag, w_idx, {s_offset{1'b0}}};
    pmem_wdata   = r_data[r_victim][w_idx];
    w_hit_upd    = 1'b0;
    w_miss       = 1'b0;
    w_fill       = 1'b0;
    unique case (r_state)
      COMPARE: begin
        if (w_req) begin
          if (w_hit) begin
            mem_resp  = 1'b1;
            w_hit_upd = 1'b1;
          end else begin
            w_miss = 1'b1;
            w_next = r_dirty[w_idx][w_victim] ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[r_victim][w_idx], w_idx, {s_offset{1'b0}}};
        if (pmem_resp) w_next = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp && !rst) begin
          w_fill = 1'b1;
          w_next = COMPARE;
        end
      end
      default: w_next = COMPARE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= COMPARE;
      r_victim <= '0;
      for (int unsigned s = 0; s < s_sets; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_miss) r_victim <= w_victim;
      if (w_hit_upd) begin
        r_plru[w_idx] <= w_plru_new;
        if (mem_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
      if (w_fill) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b0;
      end
    end
  end

  // Data and tag storage carry no reset; both write enables are already qualified by ~rst.
  always_ff @(posedge clk) begin
    if (w_hit_upd && mem_write) r_data[w_hit_way][w_idx] <= w_merged;
    if (w_fill) begin
      r_data[r_victim][w_idx] <= pmem_rdata;
      r_tag[r_victim][w_idx]  <= w_tag;
    end
  end

`ifdef CACHE_PERF_CTR_EN
  logic [31:0] r_hit_count, r_miss_count, r_wb_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_wb_count   <= '0;
    end else begin
      if (w_hit_upd) r_hit_count <= r_hit_count + 32'd1;
      if (w_miss) r_miss_count <= r_miss_count + 32'd1;
      if (r_state == WRITEBACK && pmem_resp) r_wb_count <= r_wb_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
  assign wb_count   = r_wb_count;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: a 4-way and an 8-way instance, with the bench acting as CPU and memory.
module tb_cache_nway;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         c_read [2], c_write[2], c_resp[2];
  logic         p_read [2], p_write[2], p_resp[2];
  logic [31:0]  c_addr [2], c_be[2], p_addr[2];
  logic [31:0]  hc[2], mc[2], wc[2];
  logic [255:0] c_wdata[2], c_rdata[2], p_wdata[2], p_rdata[2];

  cache_nway #(.num_ways(4)) dut4 (
    .clk(clk), .rst(rst),
    .mem_read(c_read[0]), .mem_write(c_write[0]), .mem_address(c_addr[0]),
    .mem_byte_enable256(c_be[0]), .mem_wdata256(c_wdata[0]), .mem_rdata256(c_rdata[0]),
    .mem_resp(c_resp[0]), .pmem_read(p_read[0]), .pmem_write(p_write[0]),
    .pmem_address(p_addr[0]), .pmem_wdata(p_wdata[0]), .pmem_rdata(p_rdata[0]),
    .pmem_resp(p_resp[0]), .hit_count(hc[0]), .miss_count(mc[0]), .wb_count(wc[0])
  );

  cache_nway #(.num_ways(8)) dut8 (
    .clk(clk), .rst(rst),
    .mem_read(c_read[1]), .mem_write(c_write[1]), .mem_address(c_addr[1]),
    .mem_byte_enable256(c_be[1]), .mem_wdata256(c_wdata[1]), .mem_rdata256(c_rdata[1]),
    .mem_resp(c_resp[1]), .pmem_read(p_read[1]), .pmem_write(p_write[1]),
    .pmem_address(p_addr[1]), .pmem_wdata(p_wdata[1]), .pmem_rdata(p_rdata[1]),
    .pmem_resp(p_resp[1]), .hit_count(hc[1]), .miss_count(mc[1]), .wb_count(wc[1])
  );

  int unsigned  n_total = 0;
  int unsigned  n_pass  = 0;
  int unsigned  n_fail  = 0;

  int           r_cyc, r_nwb, r_nfill;
  logic         r_wbfirst;
  logic         r_both = 1'b0;
  logic [255:0] r_rd, r_wbdata;
  logic [31:0]  r_wbaddr, r_filladdr;
  logic [255:0] exp_m;

  function automatic logic [255:0] fill(input logic [31:0] a);
    return {8{32'hA5A5_A5A5 ^ (a - 32'h100)}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU transaction; the bench answers memory requests one cycle after they appear.
  task automatic access(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] be, input logic [255:0] wd);
    c_read[d] = !wr; c_write[d] = wr; c_addr[d] = a; c_be[d] = be; c_wdata[d] = wd;
    r_cyc = 99; r_nwb = 0; r_nfill = 0; r_wbfirst = 1'b0; r_rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (p_read[d] && p_write[d]) r_both = 1'b1;
      if (c_resp[d]) begin
        r_cyc = k;
        r_rd  = c_rdata[d];
        break;
      end
      if (p_write[d]) begin
        r_nwb++;
        r_wbaddr = p_addr[d];
        r_wbdata = p_wdata[d];
        if (r_nfill == 0) r_wbfirst = 1'b1;
        p_resp[d] = 1'b1;
      end else if (p_read[d]) begin
        r_nfill++;
        r_filladdr = p_addr[d];
        p_rdata[d] = fill(p_addr[d]);
        p_resp[d]  = 1'b1;
      end
      @(posedge clk); #1;
      p_resp[d] = 1'b0;
    end
    @(posedge clk); #1;
    c_read[d] = 1'b0; c_write[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      c_read[d] = 1'b0; c_write[d] = 1'b0; c_addr[d] = '0; c_be[d] = '0;
      c_wdata[d] = '0; p_rdata[d] = '0; p_resp[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_resp", c_resp[0], 0);
    chk("rst_pmem_read", p_read[0], 0);
    chk("rst_pmem_write", p_write[0], 0);
    chk("rst_pmem_read8", p_read[1], 0);
    chk("rst_hit_count", hc[0], 0);
    @(posedge clk); #1;

    // Cold read miss, then a partial write hit and a read-back of the merged line.
    access(0, 0, 32'h100, 0, 0);
    chk("miss_latency", r_cyc, 3);
    chk("miss_fill_addr", r_filladdr, 32'h100);
    chk("miss_rdata", r_rd, {32{8'hA5}});
    access(0, 1, 32'h104, 32'h0000_00F0, {32{8'h3C}});
    chk("write_hit_latency", r_cyc, 1);
    chk("write_hit_nofill", r_nfill, 0);
    exp_m = {32{8'hA5}};
    exp_m[63:32] = 32'h3C3C_3C3C;
    access(0, 0, 32'h100, 0, 0);
    chk("merged_rdata", r_rd, exp_m);

    // Set 0: fill four ways (way 3 dirty), touch 2,0,1 so way 3 becomes the PLRU victim.
    access(0, 0, 32'h000, 0, 0);
    access(0, 0, 32'h200, 0, 0);
    access(0, 0, 32'h400, 0, 0);
    access(0, 1, 32'h600, 32'hFFFF_FFFF, {32{8'hD3}});
    chk("write_miss_latency", r_cyc, 3);
    access(0, 0, 32'h400, 0, 0);
    access(0, 0, 32'h000, 0, 0);
    access(0, 0, 32'h200, 0, 0);
    chk("touch_hit", r_cyc, 1);
    access(0, 0, 32'h800, 0, 0);
    chk("dirty_miss_latency", r_cyc, 4);
    chk("wb_count_obs", r_nwb, 1);
    chk("wb_addr_way3", r_wbaddr, 32'h600);
    chk("wb_data_way3", r_wbdata, {32{8'hD3}});
    chk("wb_before_fill", r_wbfirst, 1);
    chk("alloc_addr", r_filladdr, 32'h800);
    chk("alloc_rdata", r_rd, fill(32'h800));
    access(0, 0, 32'h000, 0, 0);
    chk("way0_survives", r_cyc, 1);

    // Set 8: evicting the earlier partially written line writes back the merged data.
    access(0, 0, 32'h300, 0, 0);
    access(0, 0, 32'h500, 0, 0);
    access(0, 0, 32'h700, 0, 0);
    access(0, 0, 32'h900, 0, 0);
    chk("set8_wb_addr", r_wbaddr, 32'h100);
    chk("set8_wb_data", r_wbdata, exp_m);
`ifdef CACHE_PERF_CTR_EN
    chk("ctr4_hit", hc[0], 16);
    chk("ctr4_miss", mc[0], 10);
    chk("ctr4_wb", wc[0], 2);
`else
    chk("ctr4_hit", hc[0], 0);
    chk("ctr4_miss", mc[0], 0);
    chk("ctr4_wb", wc[0], 0);
`endif

    // 8-way: dirty fills of tags 0..7, keep touching way 5; victims are 0, 2, 1 in turn.
    for (int t = 0; t < 8; t++) begin
      access(1, 1, 32'(t) << 9, 32'hFFFF_FFFF, {8{32'hD000_0000 + 32'(t)}});
      chk("w8_fill_latency", r_cyc, 3);
    end
    access(1, 0, 32'hA00, 0, 0);
    chk("w8_hit5", r_rd, {8{32'hD000_0005}});
    access(1, 0, 32'h1000, 0, 0);
    chk("w8_victim_a", r_wbaddr, 32'h000);
    chk("w8_victim_a_data", r_wbdata, {8{32'hD000_0000}});
    access(1, 0, 32'hA00, 0, 0);
    access(1, 0, 32'h1200, 0, 0);
    chk("w8_victim_b", r_wbaddr, 32'h400);
    access(1, 0, 32'hA00, 0, 0);
    access(1, 0, 32'h1400, 0, 0);
    chk("w8_victim_c", r_wbaddr, 32'h200);
    chk("w8_victim_c_data", r_wbdata, {8{32'hD000_0001}});
    access(1, 0, 32'hA00, 0, 0);
    chk("w8_way5_kept", r_cyc, 1);
    chk("w8_way5_data", r_rd, {8{32'hD000_0005}});
`ifdef CACHE_PERF_CTR_EN
    chk("ctr8_hit", hc[1], 15);
    chk("ctr8_miss", mc[1], 11);
    chk("ctr8_wb", wc[1], 3);
`else
    chk("ctr8_hit", hc[1], 0);
    chk("ctr8_miss", mc[1], 0);
    chk("ctr8_wb", wc[1], 0);
`endif
    chk("no_rw_overlap", r_both, 0);

    // Reset while ALLOCATE waits on memory.
    c_read[0] = 1'b1; c_addr[0] = 32'hC00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (p_read[0]) break;
      @(posedge clk); #1;
    end
    chk("alloc_reached", p_read[0], 1);
    rst = 1'b1;
    @(posedge clk); #1;
    c_read[0] = 1'b0;
    @(negedge clk);
    chk("rst_drops_pmem_read", p_read[0], 0);
    chk("rst_no_resp", c_resp[0], 0);
    chk("rst_clears_ctr", hc[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    access(0, 0, 32'hC00, 0, 0);
    chk("rst_same_addr_misses", r_cyc, 3);
    chk("rst_refill_addr", r_filladdr, 32'hC00);
    access(0, 0, 32'h000, 0, 0);
    chk("rst_invalidated", r_nfill, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
